// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: loads a word onto the data inputs of an external 8:1 mux,
// walks mux_sel across all eight positions and rebuilds the word from the
// sampled mux output. A frame takes 8 SHIFT cycles plus one DONE cycle.
// On DONE the rebuilt word is compared with the loaded word.
module mux_scan_ctrl #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [7:0] mux_in,
    output logic [2:0] mux_sel,
    input  logic       mux_y,
    output logic       bit_valid,
    output logic       frame_last,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Scan order endpoints; the select never wraps inside a frame.
    localparam logic [2:0] FIRST_SEL = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_SEL  = MSB_FIRST ? 3'd0 : 3'd7;

    state_t     state_q, state_d;
    logic [7:0] mux_in_q, mux_in_d;
    logic [2:0] mux_sel_q, mux_sel_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       load_ready_q, load_ready_d;
    logic       bit_valid_q, bit_valid_d;
    logic       frame_last_q, frame_last_d;
    logic       done_q, done_d;
    logic       match_q, match_d;

    // Next-state and datapath update; status outputs are decoded from the
    // next state so they can be registered alongside it.
    always_comb begin
        state_d   = state_q;
        mux_in_d  = mux_in_q;
        mux_sel_d = mux_sel_q;
        rx_data_d = rx_data_q;

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    mux_in_d  = load_data;
                    rx_data_d = 8'h00;
                    mux_sel_d = FIRST_SEL;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                rx_data_d[mux_sel_q] = mux_y;
                if (mux_sel_q == LAST_SEL) begin
                    // Select stays on the final index until the next load.
                    state_d = DONE;
                end else if (MSB_FIRST) begin
                    mux_sel_d = mux_sel_q - 3'd1;
                end else begin
                    mux_sel_d = mux_sel_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_ready_d = (state_d == IDLE);
        bit_valid_d  = (state_d == SHIFT);
        frame_last_d = (state_d == SHIFT) && (mux_sel_d == LAST_SEL);
        done_d       = (state_d == DONE);
        match_d      = (state_d == DONE) && (rx_data_d == mux_in_d);
    end

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mux_in_q     <= 8'h00;
            mux_sel_q    <= 3'd0;
            rx_data_q    <= 8'h00;
            load_ready_q <= 1'b1;
            bit_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mux_in_q     <= mux_in_d;
            mux_sel_q    <= mux_sel_d;
            rx_data_q    <= rx_data_d;
            load_ready_q <= load_ready_d;
            bit_valid_q  <= bit_valid_d;
            frame_last_q <= frame_last_d;
            done_q       <= done_d;
            match_q      <= match_d;
        end
    end

    assign load_ready = load_ready_q;
    assign mux_in     = mux_in_q;
    assign mux_sel    = mux_sel_q;
    assign bit_valid  = bit_valid_q;
    assign frame_last = frame_last_q;
    assign done       = done_q;
    assign rx_data    = rx_data_q;
    assign match      = match_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one LSB-first and one MSB-first instance,
// each fed by an ideal 8:1 mux model (the LSB-first one can have one select
// position forced to a stuck value).
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       lv0 = 1'b0, lv1 = 1'b0;
    logic [7:0] ld0 = 8'h00, ld1 = 8'h00;
    logic       lr0, lr1, bv0, bv1, fl0, fl1, dn0, dn1, mt0, mt1, my0, my1;
    logic [7:0] mi0, mi1, rx0, rx1;
    logic [2:0] ms0, ms1;

    logic       force_en = 1'b0;
    logic [2:0] force_sel = 3'd0;
    logic       force_val = 1'b0;

    assign my0 = (force_en && ms0 == force_sel) ? force_val : mi0[ms0];
    assign my1 = mi1[ms1];

    int checks = 0;
    int passed = 0;

    mux_scan_ctrl #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_data(ld0),
        .load_ready(lr0), .mux_in(mi0), .mux_sel(ms0), .mux_y(my0),
        .bit_valid(bv0), .frame_last(fl0), .done(dn0), .rx_data(rx0), .match(mt0)
    );

    mux_scan_ctrl #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_data(ld1),
        .load_ready(lr1), .mux_in(mi1), .mux_sel(ms1), .mux_y(my1),
        .bit_valid(bv1), .frame_last(fl1), .done(dn1), .rx_data(rx1), .match(mt1)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (lr0 !== 1'b1) $display("FAIL rst_load_ready got %b want 1", lr0); else passed++;
        checks++; if (bv0 !== 1'b0) $display("FAIL rst_bit_valid got %b want 0", bv0); else passed++;
        checks++; if (fl0 !== 1'b0) $display("FAIL rst_frame_last got %b want 0", fl0); else passed++;
        checks++; if (dn0 !== 1'b0) $display("FAIL rst_done got %b want 0", dn0); else passed++;
        checks++; if (mt0 !== 1'b0) $display("FAIL rst_match got %b want 0", mt0); else passed++;
        checks++; if (mi0 !== 8'h00) $display("FAIL rst_mux_in got %h want 00", mi0); else passed++;
        checks++; if (ms0 !== 3'd0) $display("FAIL rst_mux_sel got %0d want 0", ms0); else passed++;
        checks++; if (rx0 !== 8'h00) $display("FAIL rst_rx_data got %h want 00", rx0); else passed++;
        checks++; if (ms1 !== 3'd0) $display("FAIL rst_mux_sel_msb got %0d want 0", ms1); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_lsb_frame();
        logic [7:0] w;
        w = 8'hAA;
        lv0 = 1'b1; ld0 = w;
        checks++; if (lr0 !== 1'b1) $display("FAIL lsb_ready_before got %b want 1", lr0); else passed++;
        tick();
        lv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bv0 !== 1'b1) $display("FAIL lsb_bit_valid[%0d] got %b want 1", i, bv0); else passed++;
            checks++; if (ms0 !== 3'(i)) $display("FAIL lsb_mux_sel[%0d] got %0d want %0d", i, ms0, i); else passed++;
            checks++; if (my0 !== w[i]) $display("FAIL lsb_mux_y[%0d] got %b want %b", i, my0, w[i]); else passed++;
            checks++; if (fl0 !== (i == 7)) $display("FAIL lsb_frame_last[%0d] got %b want %b", i, fl0, (i == 7)); else passed++;
            checks++; if (lr0 !== 1'b0 || dn0 !== 1'b0) $display("FAIL lsb_ready_done[%0d] got %b%b want 00", i, lr0, dn0); else passed++;
            tick();
        end
        checks++; if (dn0 !== 1'b1) $display("FAIL lsb_done got %b want 1", dn0); else passed++;
        checks++; if (bv0 !== 1'b0 || fl0 !== 1'b0) $display("FAIL lsb_done_bv_fl got %b%b want 00", bv0, fl0); else passed++;
        checks++; if (rx0 !== 8'hAA) $display("FAIL lsb_rx_data got %h want aa", rx0); else passed++;
        checks++; if (mt0 !== 1'b1) $display("FAIL lsb_match got %b want 1", mt0); else passed++;
        tick();
        checks++; if (dn0 !== 1'b0 || lr0 !== 1'b1) $display("FAIL lsb_idle got done=%b ready=%b want 0/1", dn0, lr0); else passed++;
        checks++; if (mt0 !== 1'b0) $display("FAIL lsb_idle_match got %b want 0", mt0); else passed++;
        checks++; if (rx0 !== 8'hAA || mi0 !== 8'hAA) $display("FAIL lsb_hold got rx=%h in=%h want aa/aa", rx0, mi0); else passed++;
        checks++; if (ms0 !== 3'd7) $display("FAIL lsb_sel_hold got %0d want 7", ms0); else passed++;
    endtask

    task automatic test_msb_frame();
        lv1 = 1'b1; ld1 = 8'h81;
        tick();
        lv1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (ms1 !== 3'(7 - i)) $display("FAIL msb_mux_sel[%0d] got %0d want %0d", i, ms1, 7 - i); else passed++;
            checks++; if (fl1 !== (i == 7)) $display("FAIL msb_frame_last[%0d] got %b want %b", i, fl1, (i == 7)); else passed++;
            tick();
        end
        checks++; if (dn1 !== 1'b1) $display("FAIL msb_done got %b want 1", dn1); else passed++;
        checks++; if (rx1 !== 8'h81) $display("FAIL msb_rx_data got %h want 81", rx1); else passed++;
        checks++; if (mt1 !== 1'b1) $display("FAIL msb_match got %b want 1", mt1); else passed++;
        checks++; if (ms1 !== 3'd0) $display("FAIL msb_sel_hold got %0d want 0", ms1); else passed++;
        tick();
    endtask

    task automatic test_stuck_bit();
        force_en = 1'b1; force_sel = 3'd3; force_val = 1'b0;
        lv0 = 1'b1; ld0 = 8'hFF;
        tick();
        lv0 = 1'b0;
        repeat (8) tick();
        checks++; if (dn0 !== 1'b1) $display("FAIL stuck_done got %b want 1", dn0); else passed++;
        checks++; if (rx0 !== 8'hF7) $display("FAIL stuck_rx_data got %h want f7", rx0); else passed++;
        checks++; if (mt0 !== 1'b0) $display("FAIL stuck_match got %b want 0", mt0); else passed++;
        tick();
        force_en = 1'b0;
    endtask

    task automatic test_throughput();
        lv0 = 1'b1; ld0 = 8'h11;
        checks++; if (lr0 !== 1'b1) $display("FAIL tput_ready_k got %b want 1", lr0); else passed++;
        tick();
        for (int c = 1; c <= 9; c++) begin
            checks++; if (lr0 !== 1'b0) $display("FAIL tput_ready[%0d] got %b want 0", c, lr0); else passed++;
            checks++; if (mi0 !== 8'h11) $display("FAIL tput_mux_in[%0d] got %h want 11", c, mi0); else passed++;
            ld0 = 8'h11 + 8'(c);
            tick();
        end
        checks++; if (lr0 !== 1'b1) $display("FAIL tput_ready_k10 got %b want 1", lr0); else passed++;
        ld0 = 8'h5A;
        tick();
        checks++; if (mi0 !== 8'h5A || bv0 !== 1'b1) $display("FAIL tput_second got in=%h bv=%b want 5a/1", mi0, bv0); else passed++;
        ld0 = 8'hC3;
        repeat (8) tick();
        checks++; if (dn0 !== 1'b1 || mt0 !== 1'b1) $display("FAIL tput_second_done got done=%b match=%b want 1/1", dn0, mt0); else passed++;
        checks++; if (mi0 !== 8'h5A || rx0 !== 8'h5A) $display("FAIL tput_second_data got in=%h rx=%h want 5a/5a", mi0, rx0); else passed++;
        lv0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        lv0 = 1'b1; ld0 = 8'h96;
        tick();
        lv0 = 1'b0;
        repeat (3) tick();
        checks++; if (bv0 !== 1'b1 || ms0 !== 3'd3) $display("FAIL rmid_pre got bv=%b sel=%0d want 1/3", bv0, ms0); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (lr0 !== 1'b1) $display("FAIL rmid_ready got %b want 1", lr0); else passed++;
        checks++; if (bv0 !== 1'b0 || fl0 !== 1'b0 || dn0 !== 1'b0 || mt0 !== 1'b0) $display("FAIL rmid_flags got %b%b%b%b want 0000", bv0, fl0, dn0, mt0); else passed++;
        checks++; if (mi0 !== 8'h00 || rx0 !== 8'h00 || ms0 !== 3'd0) $display("FAIL rmid_data got in=%h rx=%h sel=%0d want 00/00/0", mi0, rx0, ms0); else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (dn0 !== 1'b0) $display("FAIL rmid_no_done[%0d] got %b want 0", i, dn0); else passed++;
            tick();
        end
        checks++; if (lr0 !== 1'b1) $display("FAIL rmid_idle got %b want 1", lr0); else passed++;
        tick();
        lv0 = 1'b1; ld0 = 8'h3C;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        lv0 = 1'b0;
        checks++; if (bv0 !== 1'b1 || mi0 !== 8'h3C) $display("FAIL rmid_first_edge got bv=%b in=%h want 1/3c", bv0, mi0); else passed++;
        repeat (8) tick();
        checks++; if (dn0 !== 1'b1 || rx0 !== 8'h3C || mt0 !== 1'b1) $display("FAIL rmid_reload got done=%b rx=%h match=%b want 1/3c/1", dn0, rx0, mt0); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        lv0 = 1'b1; ld0 = 8'h00;
        tick();
        lv0 = 1'b0;
        repeat (8) tick();
        checks++; if (dn0 !== 1'b1 || rx0 !== 8'h00 || mt0 !== 1'b1) $display("FAIL b2b_first got done=%b rx=%h match=%b want 1/00/1", dn0, rx0, mt0); else passed++;
        lv0 = 1'b1; ld0 = 8'hFF;
        tick();
        checks++; if (lr0 !== 1'b1 || mi0 !== 8'h00) $display("FAIL b2b_idle got ready=%b in=%h want 1/00", lr0, mi0); else passed++;
        tick();
        lv0 = 1'b0;
        checks++; if (bv0 !== 1'b1 || mi0 !== 8'hFF || rx0 !== 8'h00) $display("FAIL b2b_load got bv=%b in=%h rx=%h want 1/ff/00", bv0, mi0, rx0); else passed++;
        repeat (8) tick();
        checks++; if (dn0 !== 1'b1 || rx0 !== 8'hFF || mt0 !== 1'b1) $display("FAIL b2b_second got done=%b rx=%h match=%b want 1/ff/1", dn0, rx0, mt0); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_lsb_frame();
        test_msb_frame();
        test_stuck_bit();
        test_throughput();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter MSB_FIRST, default 0, meaning: 0 = scan mux_sel 0->7, 1 = scan 7->0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 load_valid  input  1  upstream offers load_data this cycle.
REQ-005 load_data  input  8  word to scan through the downstream 8:1 mux.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 mux_in  output  8  registered word driving the 8:1 mux data inputs.
REQ-008 mux_sel  output  3  registered select driving the 8:1 mux.
REQ-009 mux_y  input  1  mux output, combinationally derived from mux_in/mux_sel.
REQ-010 bit_valid  output  1  mux_sel is valid and mux_y is being sampled this cycle.
REQ-011 frame_last  output  1  current bit_valid cycle is the 8th of the frame.
REQ-012 done  output  1  one-cycle pulse, frame complete.
REQ-013 rx_data  output  8  word reassembled from sampled mux_y bits.
REQ-014 match  output  1  rx_data equals mux_in; meaningful only while done=1.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-016 IDLE: load_ready=1, bit_valid=0; a handshake occurs when load_valid=1 and load_ready=1 at a rising edge.
REQ-017 On handshake: mux_in<=load_data, rx_data<=8'h00, mux_sel<=3'd0 (3'd7 if MSB_FIRST=1), state<=SHIFT.
REQ-018 load_valid in SHIFT or DONE SHALL be ignored; load_ready=0 in those states; mux_in SHALL NOT change.
REQ-019 SHIFT: bit_valid=1 every cycle; at each rising edge rx_data[mux_sel]<=mux_y, all other rx_data bits hold.
REQ-020 SHIFT: mux_sel SHALL step +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1) per cycle, no wrap within a frame.
REQ-021 frame_last=1 exactly when state=SHIFT and mux_sel is the final index (7, or 0 if MSB_FIRST=1); next state DONE.
REQ-022 SHIFT SHALL last exactly 8 cycles, each select value 0..7 visited once.
REQ-023 DONE: lasts one cycle, done=1, bit_valid=0, match=(rx_data==mux_in), then state<=IDLE.
REQ-024 match and frame_last SHALL be 0 in all other states.
REQ-025 Latency: handshake at edge k -> SHIFT cycles k+1..k+8 -> DONE cycle k+9 -> load_ready=1 again from k+10; max throughput one word per 10 cycles.
REQ-026 mux_in and rx_data SHALL hold their values in DONE and IDLE until the next handshake.
REQ-027 mux_sel SHALL hold its last value outside SHIFT.
REQ-028 All outputs SHALL be registered or decoded from registered state only; no combinational path from load_valid or mux_y to any output.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, mux_in=8'h00, mux_sel=3'd0, rx_data=8'h00; hence load_ready=1, bit_valid=0, frame_last=0, done=0, match=0.
REQ-030 Reset asserted mid-SHIFT SHALL abort the frame with no done pulse; first edge after rst_n deasserts SHALL see IDLE.
REQ-031 A handshake SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Reset then load 8'b10101010, mux_y from ideal 8:1 model -> bit_valid 8 cycles, mux_sel 0..7, mux_y 0,1,0,1,0,1,0,1, done at k+9, rx_data=8'hAA, match=1.
REQ-033 MSB_FIRST=1, load 8'h81 -> mux_sel 7..0, frame_last with mux_sel=0, rx_data=8'h81, match=1.
REQ-034 Load 8'hFF, force mux_y=0 when mux_sel=3 -> rx_data=8'hF7, match=0 during done.
REQ-035 Hold load_valid=1 with new data every cycle -> only words at k and k+10 accepted, load_ready=0 cycles k+1..k+9, mux_in stable per frame.
REQ-036 Assert rst_n=0 during 4th SHIFT cycle -> all outputs zero immediately except load_ready=1; no done; next load 8'h3C completes with rx_data=8'h3C.
REQ-037 Back-to-back loads 8'h00 then 8'hFF -> second frame rx_data=8'hFF (cleared on load, no carry-over), match=1 both frames.
